// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared types and field constants for the direct-mapped data cache controller
package cache_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        REFILL,
        WRITE,
        DONE
    } state_t;

    localparam logic [1:0] DT_WORD = 2'b00;
    localparam logic [1:0] DT_BYTE = 2'b01;
    localparam logic [1:0] DT_HALF = 2'b10;

    localparam int WORD_W     = 32;
    localparam int TAG_W      = 8;
    localparam int IDX_W      = 4;
    localparam int LINE_WORDS = 4;

    localparam int OFF_LSB = 2;
    localparam int IDX_LSB = 4;
    localparam int TAG_LSB = 8;

    typedef struct packed {
        logic                                valid;
        logic [TAG_W-1:0]                    tag;
        logic [LINE_WORDS-1:0][WORD_W-1:0]   words;
    } line_t;

endpackage

// File: rtl/cache_line_array.sv
// rtl/cache_line_array.sv - line storage: async read, single-port sync write, valid bits cleared on rst
module cache_line_array
    import cache_pkg::*;
#(
    parameter int INDEX_WIDTH = IDX_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [INDEX_WIDTH-1:0] rd_index,
    output line_t                  rd_line,
    input  logic                   wr_en,
    input  logic [INDEX_WIDTH-1:0] wr_index,
    input  line_t                  wr_line
);

    localparam int LINES  = 1 << INDEX_WIDTH;
    localparam int BODY_W = $bits(line_t) - 1;

    logic [BODY_W-1:0] body_mem [LINES];
    logic [LINES-1:0]  valid_q;
    logic [LINES-1:0]  valid_d;

    always_comb begin
        valid_d = valid_q;
        if (wr_en) begin
            valid_d[wr_index] = wr_line.valid;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Reset wins over a same-edge write so an abandoned refill never lands.
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            body_mem[wr_index] <= wr_line[BODY_W-1:0];
        end
    end

    assign rd_line = {valid_q[rd_index], body_mem[rd_index]};

endmodule

// File: rtl/cache_ctrl_fsm.sv
// rtl/cache_ctrl_fsm.sv - write-through direct-mapped cache controller FSM; CACHE_PERF_COUNTERS_EN adds hit/miss counters
module cache_ctrl_fsm
    import cache_pkg::*;
#(
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 32,
    parameter int INDEX_WIDTH = 4,
    parameter int TAG_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    input  logic [1:0]            cpu_dataType,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  cpu_ready,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [1:0]            mem_dataType,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_valid
`ifdef CACHE_PERF_COUNTERS_EN
    ,
    output logic [15:0]           hit_count,
    output logic [15:0]           miss_count
`endif
);

    state_t                       state_q, state_d;
    logic [ADDR_WIDTH-1:0]        addr_q, addr_d;
    logic [DATA_WIDTH-1:0]        wdata_q, wdata_d;
    logic                         we_q, we_d;
    logic [1:0]                   dt_q, dt_d;
    logic                         hit_q, hit_d;
    logic [1:0]                   beat_q, beat_d;
    logic [3:0][DATA_WIDTH-1:0]   buf_q, buf_d;

    logic                         cpu_ready_q, cpu_ready_d;
    logic [DATA_WIDTH-1:0]        cpu_rdata_q, cpu_rdata_d;
    logic                         mem_req_q, mem_req_d;
    logic                         mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0]        mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0]        mem_wdata_q, mem_wdata_d;
    logic [1:0]                   mem_dt_q, mem_dt_d;

    logic [TAG_WIDTH-1:0]         tag;
    logic [INDEX_WIDTH-1:0]       idx;
    logic [1:0]                   off;
    logic [1:0]                   beat_nx;
    logic                         hit;
    line_t                        rd_line;
    line_t                        wr_line;
    logic                         wr_en;
    logic [DATA_WIDTH-1:0]        merged;
    logic [3:0][DATA_WIDTH-1:0]   fill;

    assign tag     = addr_q[TAG_LSB +: TAG_WIDTH];
    assign idx     = addr_q[IDX_LSB +: INDEX_WIDTH];
    assign off     = addr_q[OFF_LSB +: 2];
    assign beat_nx = beat_q + 2'd1;
    assign hit     = rd_line.valid && (rd_line.tag == tag);

    cache_line_array #(
        .INDEX_WIDTH (INDEX_WIDTH)
    ) u_lines (
        .clk      (clk),
        .rst      (rst),
        .rd_index (idx),
        .rd_line  (rd_line),
        .wr_en    (wr_en),
        .wr_index (idx),
        .wr_line  (wr_line)
    );

    // Store data is right-aligned; place it into the lane selected by the byte offset.
    always_comb begin
        merged = rd_line.words[off];
        case (dt_q)
            DT_BYTE: merged[{addr_q[1:0], 3'b000} +: 8]  = wdata_q[7:0];
            DT_HALF: merged[{addr_q[1], 4'b0000} +: 16]  = wdata_q[15:0];
            default: merged = wdata_q;
        endcase
    end

    always_comb begin
        fill    = buf_q;
        fill[3] = mem_rdata;
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        we_d         = we_q;
        dt_d         = dt_q;
        hit_d        = hit_q;
        beat_d       = beat_q;
        buf_d        = buf_q;
        cpu_ready_d  = 1'b0;
        cpu_rdata_d  = cpu_rdata_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_dt_d     = mem_dt_q;
        wr_en        = 1'b0;
        wr_line      = rd_line;

        case (state_q)
            IDLE: begin
                if (cpu_req) begin
                    addr_d  = cpu_addr;
                    wdata_d = cpu_wdata;
                    we_d    = cpu_we;
                    dt_d    = cpu_dataType;
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                hit_d = hit;
                if (we_q) begin
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = addr_q;
                    mem_wdata_d = wdata_q;
                    mem_dt_d    = dt_q;
                    state_d     = WRITE;
                end else if (hit) begin
                    cpu_rdata_d = rd_line.words[off];
                    cpu_ready_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    beat_d     = 2'd0;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_dt_d   = DT_WORD;
                    mem_addr_d = {tag, idx, 2'b00, 2'b00};
                    state_d    = REFILL;
                end
            end
            REFILL: begin
                if (mem_req_q && mem_valid) begin
                    buf_d[beat_q] = mem_rdata;
                    beat_d        = beat_nx;
                    mem_addr_d    = {tag, idx, beat_nx, 2'b00};
                    if (beat_q == 2'd3) begin
                        wr_en         = 1'b1;
                        wr_line.valid = 1'b1;
                        wr_line.tag   = tag;
                        wr_line.words = fill;
                        cpu_rdata_d   = fill[off];
                        cpu_ready_d   = 1'b1;
                        mem_req_d     = 1'b0;
                        state_d       = DONE;
                    end
                end
            end
            WRITE: begin
                if (mem_req_q && mem_valid) begin
                    if (hit_q) begin
                        wr_en              = 1'b1;
                        wr_line.words[off] = merged;
                    end
                    cpu_rdata_d = rd_line.words[off];
                    cpu_ready_d = 1'b1;
                    mem_req_d   = 1'b0;
                    mem_we_d    = 1'b0;
                    state_d     = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            dt_q        <= DT_WORD;
            hit_q       <= 1'b0;
            beat_q      <= 2'd0;
            buf_q       <= '0;
            cpu_ready_q <= 1'b0;
            cpu_rdata_q <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_dt_q    <= DT_WORD;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
            dt_q        <= dt_d;
            hit_q       <= hit_d;
            beat_q      <= beat_d;
            buf_q       <= buf_d;
            cpu_ready_q <= cpu_ready_d;
            cpu_rdata_q <= cpu_rdata_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_dt_q    <= mem_dt_d;
        end
    end

    assign cpu_ready    = cpu_ready_q;
    assign cpu_rdata    = cpu_rdata_q;
    assign mem_req      = mem_req_q;
    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign mem_dataType = mem_dt_q;

`ifdef CACHE_PERF_COUNTERS_EN
    logic [15:0] hit_cnt_q, hit_cnt_d;
    logic [15:0] miss_cnt_q, miss_cnt_d;

    // Loads only; stores never touch either counter.
    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (state_q == LOOKUP && !we_q) begin
            if (hit) begin
                hit_cnt_d = hit_cnt_q + 16'd1;
            end else begin
                miss_cnt_d = miss_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`endif

endmodule
